// File: rtl/miriscv_lsu_pkg.sv
// Shared types and constants for the LSU request stage.
package miriscv_lsu_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned BE_W         = XLEN / 8;
   localparam int unsigned MEM_ACCESS_W = 3;

   // Access sizes follow the load/store funct3 encoding
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'b000;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'b001;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'b010;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'b100;
   localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_RESP
   } lsu_req_state_e;

   typedef struct packed {
      logic            we;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/miriscv_lsu_req_stage_if.sv
// Request/response signals between the LSU and the data memory.
interface miriscv_lsu_req_stage_if import miriscv_lsu_pkg::*; ();

   logic            data_req;
   logic            data_we;
   logic [BE_W-1:0] data_be;
   logic [XLEN-1:0] data_addr;
   logic [XLEN-1:0] data_wdata;
   logic            data_gnt;
   logic            data_rvalid;

   modport master (
      output data_req, data_we, data_be, data_addr, data_wdata,
      input  data_gnt, data_rvalid
   );

   modport slave (
      input  data_req, data_we, data_be, data_addr, data_wdata,
      output data_gnt, data_rvalid
   );

endinterface

// File: rtl/miriscv_lsu_be_gen.sv
// Byte-enable, store-data lane alignment and misalignment detection.
module miriscv_lsu_be_gen
   import miriscv_lsu_pkg::*;
(
   input  logic [MEM_ACCESS_W-1:0] size_i,
   input  logic [1:0]              offs_i,
   input  logic [XLEN-1:0]         wdata_i,
   output logic [BE_W-1:0]         be_o,
   output logic [XLEN-1:0]         wdata_o,
   output logic                    misaligned_o
);

   always_comb begin
      be_o         = '0;
      misaligned_o = 1'b0;
      case (size_i)
         MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: begin
            be_o = BE_W'(1) << offs_i;
         end
         MEM_ACCESS_HALF, MEM_ACCESS_UHALF: begin
            be_o         = BE_W'(3) << offs_i;
            misaligned_o = (offs_i == 2'b11);
         end
         MEM_ACCESS_WORD: begin
            be_o         = '1;
            misaligned_o = (offs_i != 2'b00);
         end
         default: ;
      endcase
      wdata_o = wdata_i << {offs_i, 3'b000};
   end

endmodule

// File: rtl/miriscv_lsu_req_stage.sv
// Execute-stage data memory request initiator: issues one load/store at a
// time, holds it until granted and tracks it until its response returns.
module miriscv_lsu_req_stage
   import miriscv_lsu_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    arstn_i,
   input  logic                    e_valid_i,
   input  logic                    e_mem_req_i,
   input  logic                    e_mem_we_i,
   input  logic [MEM_ACCESS_W-1:0] e_mem_size_i,
   input  logic [XLEN-1:0]         e_mem_addr_i,
   input  logic [XLEN-1:0]         e_mem_wdata_i,
   input  logic                    cu_stall_e_i,
   input  logic                    cu_kill_e_i,
   output logic                    lsu_stall_req_o,
   output logic                    lsu_misaligned_o,
   output logic                    lsu_rvalid_o,
   miriscv_lsu_req_stage_if.master data_if
);

   lsu_req_state_e  state_q, state_d;
   lsu_req_t        req_q, req_d, req_new;
   logic            issued_q, issued_d;
   logic            drop_q, drop_d;
   logic [BE_W-1:0] be;
   logic [XLEN-1:0] wdata_al;
   logic            misaligned;
   logic            accept;

   miriscv_lsu_be_gen u_be_gen (
      .size_i       (e_mem_size_i),
      .offs_i       (e_mem_addr_i[1:0]),
      .wdata_i      (e_mem_wdata_i),
      .be_o         (be),
      .wdata_o      (wdata_al),
      .misaligned_o (misaligned)
   );

   assign lsu_misaligned_o = e_valid_i & e_mem_req_i & misaligned;
   assign accept = e_valid_i & e_mem_req_i & ~cu_kill_e_i & ~misaligned & ~issued_q;

   always_comb begin
      req_new.we    = e_mem_we_i;
      req_new.be    = be;
      req_new.addr  = {e_mem_addr_i[XLEN-1:2], 2'b00};
      req_new.wdata = e_mem_we_i ? wdata_al : '0;
   end

   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      lsu_stall_req_o = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            lsu_stall_req_o = accept;
            if (accept) begin
               state_d = LSU_REQ;
               req_d   = req_new;
            end
         end
         LSU_REQ: begin
            lsu_stall_req_o = ~data_if.data_gnt;
            if (data_if.data_gnt) begin
               state_d = LSU_RESP;
            end
         end
         LSU_RESP: begin
            lsu_stall_req_o = accept;
            if (data_if.data_rvalid) begin
               if (accept) begin
                  state_d = LSU_REQ;
                  req_d   = req_new;
               end else begin
                  state_d = LSU_IDLE;
               end
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   // issued_q only survives while E is held, so a stalled E never re-issues
   always_comb begin
      issued_d = cu_stall_e_i & (issued_q | ((state_q == LSU_REQ) & data_if.data_gnt));
   end

   // A killed request still goes out; its response is swallowed instead
   always_comb begin
      drop_d = drop_q;
      if ((state_q == LSU_RESP) && data_if.data_rvalid) begin
         drop_d = 1'b0;
      end
      if ((state_q == LSU_REQ) && cu_kill_e_i) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q  <= LSU_IDLE;
         req_q    <= '0;
         issued_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         issued_q <= issued_d;
         drop_q   <= drop_d;
      end
   end

   assign lsu_rvalid_o       = data_if.data_rvalid & ~drop_q & (state_q == LSU_RESP);
   assign data_if.data_req   = (state_q == LSU_REQ);
   assign data_if.data_we    = req_q.we;
   assign data_if.data_be    = req_q.be;
   assign data_if.data_addr  = req_q.addr;
   assign data_if.data_wdata = req_q.wdata;

endmodule

// File: tb/tb_miriscv_lsu_req_stage.sv
// Self-checking bench for miriscv_lsu_req_stage: vector table plus directed
// sequences, with issued requests checked against a scoreboard queue.
module tb_miriscv_lsu_req_stage;
   import miriscv_lsu_pkg::*;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      logic [2:0]  size;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          req_cycles;
      int          rsp_dly;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] wdata_exp;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        e_valid, e_mem_req, e_mem_we, cu_kill, tb_stall;
   logic [2:0]  e_mem_size;
   logic [31:0] e_mem_addr, e_mem_wdata;
   logic        cu_stall_e, lsu_stall_req, lsu_misaligned, lsu_rvalid;

   int n_checks = 0;
   int n_errs   = 0;
   exp_t exp_q[$];
   vec_t vecs[11];

   miriscv_lsu_req_stage_if mem_if ();

   assign cu_stall_e = lsu_stall_req | tb_stall;

   miriscv_lsu_req_stage dut (
      .clk_i            (clk_i),
      .arstn_i          (arstn_i),
      .e_valid_i        (e_valid),
      .e_mem_req_i      (e_mem_req),
      .e_mem_we_i       (e_mem_we),
      .e_mem_size_i     (e_mem_size),
      .e_mem_addr_i     (e_mem_addr),
      .e_mem_wdata_i    (e_mem_wdata),
      .cu_stall_e_i     (cu_stall_e),
      .cu_kill_e_i      (cu_kill),
      .lsu_stall_req_o  (lsu_stall_req),
      .lsu_misaligned_o (lsu_misaligned),
      .lsu_rvalid_o     (lsu_rvalid),
      .data_if          (mem_if)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_e(input logic [2:0] size, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
      e_valid     = 1'b1;
      e_mem_req   = 1'b1;
      e_mem_size  = size;
      e_mem_we    = we;
      e_mem_addr  = addr;
      e_mem_wdata = wdata;
   endtask

   task automatic push_exp(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
      exp_t e;
      e.we    = we;
      e.be    = be;
      e.addr  = addr & 32'hFFFF_FFFC;
      e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   // Called in a grant cycle: the request on the bus must match the oldest expectation
   task automatic check_grant();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("sb_unexpected_req", 32'(mem_if.data_req), 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("sb_we",    32'(mem_if.data_we), 32'(e.we));
         chk("sb_be",    32'(mem_if.data_be), 32'(e.be));
         chk("sb_addr",  mem_if.data_addr,    e.addr);
         chk("sb_wdata", mem_if.data_wdata,   e.wdata);
      end
   endtask

   task automatic run_txn(input vec_t v);
      drive_e(v.size, v.we, v.addr, v.wdata);
      mem_if.data_gnt    = 1'b0;
      mem_if.data_rvalid = 1'b0;
      if (v.mis) begin
         @(negedge clk_i);
         chk("mis_flag",  32'(lsu_misaligned), 32'd1);
         chk("mis_req",   32'(mem_if.data_req), 32'd0);
         chk("mis_stall", 32'(lsu_stall_req),  32'd0);
         tick();
         e_valid = 1'b0;
         @(negedge clk_i);
         chk("mis_idle_req", 32'(mem_if.data_req), 32'd0);
         tick();
         return;
      end
      push_exp(v.we, v.be, v.addr, v.wdata_exp);
      @(negedge clk_i);
      chk("cap_mis",   32'(lsu_misaligned), 32'd0);
      chk("cap_stall", 32'(lsu_stall_req),  32'd1);
      chk("cap_req",   32'(mem_if.data_req), 32'd0);
      tick();
      for (int c = 1; c <= v.req_cycles; c++) begin
         mem_if.data_gnt = (c == v.req_cycles);
         @(negedge clk_i);
         chk("req_high", 32'(mem_if.data_req), 32'd1);
         if (c == v.req_cycles) begin
            chk("gnt_stall", 32'(lsu_stall_req), 32'd0);
            check_grant();
         end else begin
            chk("req_stall", 32'(lsu_stall_req), 32'd1);
         end
         tick();
      end
      e_valid         = 1'b0;
      mem_if.data_gnt = 1'b0;
      for (int c = 1; c <= v.rsp_dly; c++) begin
         mem_if.data_rvalid = (c == v.rsp_dly);
         @(negedge clk_i);
         chk("resp_req",    32'(mem_if.data_req), 32'd0);
         chk("resp_rvalid", 32'(lsu_rvalid), (c == v.rsp_dly) ? 32'd1 : 32'd0);
         tick();
      end
      mem_if.data_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{MEM_ACCESS_BYTE,  1'b1, 32'h0000_1001, 32'h1234_56A5, 2, 1, 1'b0, 4'b0010, 32'h3456_A500};
      vecs[1]  = '{MEM_ACCESS_WORD,  1'b0, 32'h0000_2000, 32'hFFFF_FFFF, 1, 1, 1'b0, 4'b1111, 32'h0};
      vecs[2]  = '{MEM_ACCESS_WORD,  1'b0, 32'h0000_2002, 32'h0,         1, 1, 1'b1, 4'b0000, 32'h0};
      vecs[3]  = '{MEM_ACCESS_HALF,  1'b0, 32'h0000_2003, 32'h0,         1, 1, 1'b1, 4'b0000, 32'h0};
      vecs[4]  = '{MEM_ACCESS_HALF,  1'b0, 32'h0000_2001, 32'h0,         1, 2, 1'b0, 4'b0110, 32'h0};
      vecs[5]  = '{MEM_ACCESS_HALF,  1'b1, 32'h0000_3002, 32'h0000_BEEF, 1, 1, 1'b0, 4'b1100, 32'hBEEF_0000};
      vecs[6]  = '{MEM_ACCESS_WORD,  1'b1, 32'h0000_4004, 32'hDEAD_BEEF, 3, 3, 1'b0, 4'b1111, 32'hDEAD_BEEF};
      vecs[7]  = '{MEM_ACCESS_UBYTE, 1'b0, 32'h0000_5003, 32'hAAAA_AAAA, 1, 1, 1'b0, 4'b1000, 32'h0};
      vecs[8]  = '{MEM_ACCESS_BYTE,  1'b1, 32'h0000_6000, 32'hFFFF_FF7E, 2, 1, 1'b0, 4'b0001, 32'hFFFF_FF7E};
      vecs[9]  = '{MEM_ACCESS_UHALF, 1'b0, 32'h0000_7002, 32'h0,         1, 2, 1'b0, 4'b1100, 32'h0};
      vecs[10] = '{MEM_ACCESS_WORD,  1'b1, 32'h0000_0011, 32'h1,         1, 1, 1'b1, 4'b0000, 32'h0};

      arstn_i = 1'b0;
      e_valid = 1'b0; e_mem_req = 1'b0; e_mem_we = 1'b0; cu_kill = 1'b0; tb_stall = 1'b0;
      e_mem_size = MEM_ACCESS_WORD; e_mem_addr = '0; e_mem_wdata = '0;
      mem_if.data_gnt = 1'b0; mem_if.data_rvalid = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_req",   32'(mem_if.data_req),  32'd0);
      chk("rst_we",    32'(mem_if.data_we),   32'd0);
      chk("rst_be",    32'(mem_if.data_be),   32'd0);
      chk("rst_addr",  mem_if.data_addr,      32'd0);
      chk("rst_wdata", mem_if.data_wdata,     32'd0);
      chk("rst_stall", 32'(lsu_stall_req),    32'd0);
      chk("rst_rvalid", 32'(lsu_rvalid),      32'd0);
      tick();
      arstn_i = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i]);
         tick();
      end

      // Kill while the request waits three cycles for grant
      drive_e(MEM_ACCESS_WORD, 1'b0, 32'h0000_8000, 32'h0);
      push_exp(1'b0, 4'b1111, 32'h0000_8000, 32'h0);
      @(negedge clk_i);
      tick();
      cu_kill = 1'b1;
      e_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         mem_if.data_gnt = (c == 4);
         @(negedge clk_i);
         chk("kill_req_held", 32'(mem_if.data_req), 32'd1);
         if (c == 4) check_grant();
         tick();
         cu_kill = 1'b0;
      end
      mem_if.data_gnt    = 1'b0;
      mem_if.data_rvalid = 1'b1;
      @(negedge clk_i);
      chk("kill_rvalid_dropped", 32'(lsu_rvalid), 32'd0);
      tick();
      mem_if.data_rvalid = 1'b0;
      run_txn(vecs[1]);
      tick();

      // E held 4 cycles after grant: exactly one request
      drive_e(MEM_ACCESS_WORD, 1'b1, 32'h0000_B000, 32'h1122_3344);
      push_exp(1'b1, 4'b1111, 32'h0000_B000, 32'h1122_3344);
      @(negedge clk_i);
      tick();
      mem_if.data_gnt = 1'b1;
      tb_stall        = 1'b1;
      @(negedge clk_i);
      chk("stall_gnt_req", 32'(mem_if.data_req), 32'd1);
      check_grant();
      tick();
      mem_if.data_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_if.data_rvalid = (k == 0);
         @(negedge clk_i);
         chk("stall_no_reissue", 32'(mem_if.data_req), 32'd0);
         chk("stall_no_accept",  32'(lsu_stall_req),  32'd0);
         chk("stall_rvalid",     32'(lsu_rvalid), (k == 0) ? 32'd1 : 32'd0);
         tick();
      end
      mem_if.data_rvalid = 1'b0;
      tb_stall = 1'b0;
      @(negedge clk_i);
      chk("stall_release_req", 32'(mem_if.data_req), 32'd0);
      tick();
      e_valid = 1'b0;
      @(negedge clk_i);
      chk("stall_after_req", 32'(mem_if.data_req), 32'd0);
      tick();
      run_txn(vecs[5]);
      tick();

      // Back-to-back: response and new accept in the same cycle
      drive_e(MEM_ACCESS_WORD, 1'b1, 32'h0000_9000, 32'hCAFE_F00D);
      push_exp(1'b1, 4'b1111, 32'h0000_9000, 32'hCAFE_F00D);
      @(negedge clk_i);
      tick();
      mem_if.data_gnt = 1'b1;
      @(negedge clk_i);
      check_grant();
      tick();
      mem_if.data_gnt = 1'b0;
      drive_e(MEM_ACCESS_BYTE, 1'b1, 32'h0000_9003, 32'h0000_005A);
      push_exp(1'b1, 4'b1000, 32'h0000_9003, 32'h5A00_0000);
      mem_if.data_rvalid = 1'b1;
      @(negedge clk_i);
      chk("b2b_rvalid", 32'(lsu_rvalid),       32'd1);
      chk("b2b_stall",  32'(lsu_stall_req),    32'd1);
      chk("b2b_req_lo", 32'(mem_if.data_req),  32'd0);
      tick();
      mem_if.data_rvalid = 1'b0;
      mem_if.data_gnt    = 1'b1;
      @(negedge clk_i);
      chk("b2b_req_hi", 32'(mem_if.data_req), 32'd1);
      check_grant();
      tick();
      mem_if.data_gnt    = 1'b0;
      e_valid            = 1'b0;
      mem_if.data_rvalid = 1'b1;
      @(negedge clk_i);
      chk("b2b_rvalid2", 32'(lsu_rvalid), 32'd1);
      tick();
      mem_if.data_rvalid = 1'b0;
      tick();

      // Asynchronous reset while a request is pending
      drive_e(MEM_ACCESS_WORD, 1'b0, 32'h0000_A000, 32'h0);
      @(negedge clk_i);
      tick();
      e_valid = 1'b0;
      @(negedge clk_i);
      chk("arst_pre_req", 32'(mem_if.data_req), 32'd1);
      #1 arstn_i = 1'b0;
      #1;
      chk("arst_req_async", 32'(mem_if.data_req), 32'd0);
      chk("arst_be",        32'(mem_if.data_be),  32'd0);
      chk("arst_addr",      mem_if.data_addr,     32'd0);
      tick();
      arstn_i = 1'b1;
      mem_if.data_rvalid = 1'b1;
      @(negedge clk_i);
      chk("arst_stale_rvalid", 32'(lsu_rvalid),      32'd0);
      chk("arst_idle_req",     32'(mem_if.data_req), 32'd0);
      tick();
      mem_if.data_rvalid = 1'b0;
      run_txn(vecs[6]);
      tick();

      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/miriscv_lsu_req_stage.md
Name: miriscv_lsu_req_stage

Overview:
- Request-side initiator of the data memory interface in the execute stage.
- Consumes load/store requests from E and drives data_req/we/be/addr/wdata until the memory grants them.
- Tracks the single outstanding transaction until data_rvalid, and flags misaligned accesses.
- The memory-data stage downstream consumes the response (data_rvalid/data_rdata) and performs load extraction.

Parameters:
- XLEN, 32, data/address width (from miriscv_pkg).
- BE_W, XLEN/8, byte-enable width.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  async active-low reset
- e_valid_i  in  1  instruction in E is valid
- e_mem_req_i  in  1  instruction is load/store
- e_mem_we_i  in  1  1 = store
- e_mem_size_i  in  MEM_ACCESS_W  MEM_ACCESS_{WORD,HALF,BYTE,UHALF,UBYTE}
- e_mem_addr_i  in  XLEN  effective address
- e_mem_wdata_i  in  XLEN  store data (rs2), LSB-justified
- cu_stall_e_i  in  1  E held by control unit
- cu_kill_e_i  in  1  E instruction flushed
- lsu_stall_req_o  out  1  hold E: request not yet granted
- lsu_misaligned_o  out  1  misaligned access detected (combinational)
- lsu_rvalid_o  out  1  data_rvalid_i for a non-dropped transaction
- data_req_o  out  1
- data_we_o  out  1
- data_be_o  out  BE_W
- data_addr_o  out  XLEN  word-aligned ({addr[XLEN-1:2],2'b00})
- data_wdata_o  out  XLEN
- data_gnt_i  in  1
- data_rvalid_i  in  1

Behaviour:
- Reset: arstn_i asynchronous, active-low. State IDLE. issued_q=0, drop_q=0. All data_* outputs and all registered fields 0.
- Reset mid-transaction: abandon the transaction; the next response is not tracked.
- Misaligned definition:
  - WORD with addr[1:0]!=0.
  - HALF/UHALF with addr[1:0]==2'b11.
  - Byte accesses are never misaligned.
- lsu_misaligned_o = e_valid_i & e_mem_req_i & misaligned. A misaligned access is never issued.
- accept = e_valid_i & e_mem_req_i & ~cu_kill_e_i & ~misaligned & ~issued_q.
- Byte enables:
  - byte: 4'b0001<<a
  - half: 4'b0011<<a
  - word: 4'b1111
  - a = addr[1:0]
- Store data: wdata = e_mem_wdata_i << (8*a).
- Loads: data_wdata_o=0, data_we_o=0.
- FSM:
  - IDLE: on accept, capture we/be/addr/wdata into registers; next REQ.
  - REQ:
    - data_req_o=1; outputs come from registers and are stable until grant.
    - On data_gnt_i: next RESP; set issued_q.
    - Grant in the first REQ cycle is legal.
  - RESP: waits for data_rvalid_i.
    - On rvalid with accept: capture and go to REQ (back-to-back).
    - On rvalid without accept: go to IDLE.
    - No new capture before rvalid.
- Single outstanding transaction only. rvalid in the same cycle as gnt is illegal (the memory guarantees a response latency ≥1).
- lsu_stall_req_o:
  - IDLE/RESP: = accept (covers the capture cycle, and RESP waiting for rvalid before a new capture).
  - REQ: = ~data_gnt_i (E released in the grant cycle).
- issued_q: cleared when cu_stall_e_i=0 (E advances). Prevents re-issue while E stays stalled after grant.
- Kill in REQ: a request cannot be retracted.
  - Keep data_req_o until grant, then set drop_q.
  - lsu_rvalid_o = data_rvalid_i & ~drop_q.
  - drop_q clears on that rvalid.
- Kill in IDLE: no capture.
- data_rvalid_i in IDLE is ignored.

Decomposition:
- miriscv_lsu_pkg: add typedef enum logic[1:0] lsu_req_state_e {LSU_IDLE, LSU_REQ, LSU_RESP}; reuse the MEM_ACCESS_* constants.
- Sub-module miriscv_lsu_be_gen (combinational): size + addr[1:0] + wdata -> be, aligned wdata, misaligned.

Test Plan:
- SB, addr 0x1001, wdata 0x123456A5, gnt after 2 cycles:
  - data_req_o high 2 cycles; be=4'b0010; addr 0x1000; wdata 0x3456A500; we=1.
  - Stall deasserts in the gnt cycle.
- LW, addr 0x2000, gnt same cycle as req, rvalid +1: REQ 1 cycle → RESP → IDLE; lsu_rvalid_o=1 once; be=4'hF.
- LW addr 0x2002, and LH addr 0x2003:
  - lsu_misaligned_o=1; data_req_o stays 0; state IDLE.
  - LH at 0x2001 issues with be=4'b0110.
- Kill during REQ (gnt delayed 3 cycles):
  - req held to gnt; data_rvalid_i pulses but lsu_rvalid_o=0.
  - Following LW completes normally.
- E stalled 4 cycles after gnt: exactly one request issued; issued_q clears when cu_stall_e_i drops.
- Back-to-back: rvalid in RESP coincides with a new SW accept → direct RESP→REQ, no idle cycle.
- arstn_i low during REQ: data_req_o=0 asynchronously; state IDLE; following access OK.
